// File: rtl/gt_pkg.sv
// Shared definitions for the GT common-block reset controllers:
// the QPLL FSM state encoding and default timing constants.
package gt_pkg;

   typedef enum logic [2:0] {
      ST_INIT      = 3'd0,
      ST_RESET     = 3'd1,
      ST_WAIT_LOCK = 3'd2,
      ST_STABLE    = 3'd3,
      ST_READY     = 3'd4,
      ST_FAIL      = 3'd5
   } qpll_state_e;

   localparam int unsigned DEF_INIT_WAIT_CYC    = 500;
   localparam int unsigned DEF_RST_PULSE_CYC    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT_CYC = 50000;
   localparam int unsigned DEF_LOCK_STABLE_CYC  = 256;
   localparam int unsigned DEF_MAX_RETRY        = 7;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into clk_i.
module sync_2ff (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: sequential state uses non-blocking assignments so both flops sample the pre-edge values.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/qpll_reset_ctrl.sv
// QPLL reset sequencer: holds the PLL in reset after power-up, pulses it,
// waits for a stable lock, and retries on timeout until it gives up.
module qpll_reset_ctrl
   import gt_pkg::*;
#(
   parameter int unsigned INIT_WAIT_CYC    = DEF_INIT_WAIT_CYC,
   parameter int unsigned RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
   parameter int unsigned LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
   parameter int unsigned LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
   parameter int unsigned MAX_RETRY        = DEF_MAX_RETRY
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       soft_reset_i,
   input  logic       qpll_lock_i,
   input  logic       qpll_ref_clk_lost_i,
   output logic       qpll_reset_o,
   output logic       qpll_ready_o,
   output logic       qpll_fail_o,
   output logic [2:0] retry_cnt_o,
   output logic [2:0] state_o
);

   localparam int unsigned INIT_W   = $clog2(INIT_WAIT_CYC) + 1;
   localparam int unsigned PULSE_W  = $clog2(RST_PULSE_CYC) + 1;
   localparam int unsigned TMO_W    = $clog2(LOCK_TIMEOUT_CYC) + 1;
   localparam int unsigned STABLE_W = $clog2(LOCK_STABLE_CYC) + 1;

   localparam logic [INIT_W-1:0]   INIT_LAST   = INIT_W'(INIT_WAIT_CYC - 1);
   localparam logic [PULSE_W-1:0]  PULSE_LAST  = PULSE_W'(RST_PULSE_CYC - 1);
   localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [TMO_W-1:0]    TMO_SAT     = TMO_W'(LOCK_TIMEOUT_CYC);
   localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYC - 1);
   localparam logic [2:0]          RETRY_MAX   = 3'(MAX_RETRY);

   logic lock_s;
   logic lost_s;

   sync_2ff u_sync_lock (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (qpll_lock_i),
      .q_o     (lock_s)
   );

   sync_2ff u_sync_lost (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (qpll_ref_clk_lost_i),
      .q_o     (lost_s)
   );

   qpll_state_e          state_q, state_d;
   logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
   logic [PULSE_W-1:0]   pulse_cnt_q, pulse_cnt_d;
   logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic [STABLE_W-1:0]  stable_cnt_q, stable_cnt_d;
   logic [2:0]           retry_q, retry_d;
   logic                 qpll_reset_q, qpll_ready_q, qpll_fail_q;

   // NOTE: every signal gets its default first so no branch can infer a latch.
   always_comb begin
      state_d      = state_q;
      init_cnt_d   = init_cnt_q;
      pulse_cnt_d  = pulse_cnt_q;
      tmo_cnt_d    = tmo_cnt_q;
      stable_cnt_d = stable_cnt_q;
      retry_d      = retry_q;

      if (soft_reset_i) begin
         state_d    = ST_INIT;
         init_cnt_d = '0;
         retry_d    = '0;
      end else begin
         unique case (state_q)
            ST_INIT: begin
               if (lost_s) begin
                  init_cnt_d = '0;
               end else if (init_cnt_q == INIT_LAST) begin
                  state_d     = ST_RESET;
                  pulse_cnt_d = '0;
               end else begin
                  init_cnt_d = init_cnt_q + 1'b1;
               end
            end

            ST_RESET: begin
               if (lost_s) begin
                  state_d    = ST_INIT;
                  init_cnt_d = '0;
               end else if (pulse_cnt_q == PULSE_LAST) begin
                  state_d   = ST_WAIT_LOCK;
                  tmo_cnt_d = '0;
               end else begin
                  pulse_cnt_d = pulse_cnt_q + 1'b1;
               end
            end

            ST_WAIT_LOCK, ST_STABLE: begin
               if (tmo_cnt_q != TMO_SAT) tmo_cnt_d = tmo_cnt_q + 1'b1;
               if (lost_s) begin
                  state_d    = ST_INIT;
                  init_cnt_d = '0;
               end else if (tmo_cnt_q >= TMO_LAST) begin
                  if (retry_q == RETRY_MAX) begin
                     state_d = ST_FAIL;
                  end else begin
                     retry_d     = retry_q + 3'd1;
                     state_d     = ST_RESET;
                     pulse_cnt_d = '0;
                  end
               end else if (state_q == ST_WAIT_LOCK) begin
                  if (lock_s) begin
                     state_d      = ST_STABLE;
                     stable_cnt_d = '0;
                  end
               end else if (!lock_s) begin
                  state_d = ST_WAIT_LOCK;
               end else if (stable_cnt_q == STABLE_LAST) begin
                  state_d = ST_READY;
               end else begin
                  stable_cnt_d = stable_cnt_q + 1'b1;
               end
            end

            ST_READY: begin
               if (lost_s) begin
                  state_d    = ST_INIT;
                  init_cnt_d = '0;
               end else if (!lock_s) begin
                  state_d     = ST_RESET;
                  pulse_cnt_d = '0;
                  retry_d     = '0;
               end
            end

            ST_FAIL: ;

            default: begin
               state_d    = ST_INIT;
               init_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= ST_INIT;
         init_cnt_q   <= '0;
         pulse_cnt_q  <= '0;
         tmo_cnt_q    <= '0;
         stable_cnt_q <= '0;
         retry_q      <= '0;
         qpll_reset_q <= 1'b1;
         qpll_ready_q <= 1'b0;
         qpll_fail_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_cnt_q   <= init_cnt_d;
         pulse_cnt_q  <= pulse_cnt_d;
         tmo_cnt_q    <= tmo_cnt_d;
         stable_cnt_q <= stable_cnt_d;
         retry_q      <= retry_d;
         // Flags follow the next state so they change in the same edge as state_o.
         qpll_reset_q <= (state_d == ST_INIT) || (state_d == ST_RESET) || (state_d == ST_FAIL);
         qpll_ready_q <= (state_d == ST_READY);
         qpll_fail_q  <= (state_d == ST_FAIL);
      end
   end

   assign qpll_reset_o = qpll_reset_q;
   assign qpll_ready_o = qpll_ready_q;
   assign qpll_fail_o  = qpll_fail_q;
   assign retry_cnt_o  = retry_q;
   assign state_o      = state_q;

endmodule
